icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 113 +++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache between the IF stage and the memory controller.
// Hits return after one cycle. Misses issue a single-word refill and wait for it.
module icache #(
    parameter int ICACHE_LINES = 64,
    parameter int INDEX_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        valid_2if,
    output logic [31:0] instr_2if,
    output logic        fet_ena,
    output logic [31:0] instr_addr,
    input  logic        valid_from_mc,
    input  logic [31:0] data_from_mc
);

    localparam int TAG_W = 32 - INDEX_W - 2;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] RESP     = 2'd2;

    logic [1:0]              state;
    logic                    cancel;
    logic [ICACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
    logic [31:0]             line_data [ICACHE_LINES];

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               accept;
    logic               fill;

    assign req_idx  = fetch_pc[INDEX_W+1:2];
    assign req_tag  = fetch_pc[31:INDEX_W+2];
    assign fill_idx = instr_addr[INDEX_W+1:2];
    assign fill_tag = instr_addr[31:INDEX_W+2];
    assign hit      = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign accept   = rdy && (state == IDLE) && fetch_req && !flush;
    assign fill     = rdy && (state == WAIT_MEM) && valid_from_mc;

    // Tag and data arrays: written only by a completed refill.
    always_ff @(posedge clk) begin
        if (fill) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= data_from_mc;
        end
    end

    // Valid bits: reset wipes the whole cache, a refill validates its line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid <= '0;
        end else if (fill) begin
            line_valid[fill_idx] <= 1'b1;
        end
    end

    // Lookup / refill controller and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cancel     <= 1'b0;
            valid_2if  <= 1'b0;
            instr_2if  <= '0;
            fet_ena    <= 1'b0;
            instr_addr <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (accept && hit) begin
                        instr_2if <= line_data[req_idx];
                        valid_2if <= 1'b1;
                        state     <= RESP;
                    end else if (accept) begin
                        fet_ena    <= 1'b1;
                        instr_addr <= {fetch_pc[31:2], 2'b00};
                        state      <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (valid_from_mc) begin
                        fet_ena   <= 1'b0;
                        instr_2if <= data_from_mc;
                        valid_2if <= !(cancel || flush);
                        cancel    <= 1'b0;
                        state     <= RESP;
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                RESP: begin
                    valid_2if <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    valid_2if <= 1'b0;
                    fet_ena   <= 1'b0;
                    cancel    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
